// File: rtl/user_bram_wb_prefetch.sv
// Wishbone slave for mprjram: fixed-latency backing BRAM plus a one-word
// sequential read prefetch buffer and a saturating prefetch-hit counter.
module user_bram_wb_prefetch #(
   parameter int unsigned DELAYS  = 10,
   parameter int unsigned ADDR_W  = 10,
   parameter logic [7:0]  BASE_HI = 8'h38
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [15:0] hit_cnt_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_ACK    = 2'd2;
   localparam logic [7:0] LAT_M1   = 8'(DELAYS - 1);

   logic [31:0]       mem [2**ADDR_W];

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       wdat_q, wdat_d;
   logic [31:0]       dat_q, dat_d;
   logic              hit_q, hit_d;
   logic [15:0]       hit_cnt_q, hit_cnt_d;
   logic              pf_v_q, pf_v_d;
   logic              pf_busy_q, pf_busy_d;
   logic [ADDR_W-1:0] pf_idx_q, pf_idx_d;
   logic [7:0]        pf_cnt_q, pf_cnt_d;
   logic [31:0]       pf_dat_q, pf_dat_d;

   logic              req;
   logic [ADDR_W-1:0] req_idx;
   logic              pf_match;

   assign req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
   assign req_idx  = wbs_adr_i[ADDR_W+1:2];
   assign pf_match = ~wbs_we_i & (req_idx == pf_idx_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      we_d      = we_q;
      sel_d     = sel_q;
      wdat_d    = wdat_q;
      dat_d     = dat_q;
      hit_d     = hit_q;
      hit_cnt_d = hit_cnt_q;
      pf_v_d    = pf_v_q;
      pf_busy_d = pf_busy_q;
      pf_idx_d  = pf_idx_q;
      pf_cnt_d  = pf_cnt_q;
      pf_dat_d  = pf_dat_q;

      // background prefetch countdown; request handling below may override it
      if (pf_busy_q) begin
         if (pf_cnt_q == 8'd1) begin
            pf_busy_d = 1'b0;
            pf_v_d    = 1'b1;
            pf_dat_d  = mem[pf_idx_q];
         end else begin
            pf_cnt_d = pf_cnt_q - 8'd1;
         end
      end

      case (state_q)
         S_IDLE: if (req) begin
            idx_d  = req_idx;
            we_d   = wbs_we_i;
            sel_d  = wbs_sel_i;
            wdat_d = wbs_dat_i;
            hit_d  = 1'b0;
            if (pf_match && pf_v_q) begin
               hit_d   = 1'b1;
               dat_d   = pf_dat_q;
               state_d = S_ACK;
            end else if (pf_match && pf_busy_q) begin
               // ride the in-flight prefetch instead of restarting the access
               hit_d = 1'b1;
               if (pf_cnt_q == 8'd1) begin
                  dat_d   = mem[req_idx];
                  state_d = S_ACK;
               end else begin
                  cnt_d   = pf_cnt_q - 8'd1;
                  state_d = S_ACCESS;
               end
            end else begin
               cnt_d   = LAT_M1;
               state_d = S_ACCESS;
               if (pf_busy_q) begin
                  pf_busy_d = 1'b0;
                  pf_v_d    = 1'b0;
               end
               if (wbs_we_i && req_idx == pf_idx_q) pf_v_d = 1'b0;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 8'd1) begin
               dat_d   = we_q ? 32'd0 : mem[idx_q];
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
            if (hit_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            if (!we_q) begin
               pf_busy_d = 1'b1;
               pf_v_d    = 1'b0;
               pf_idx_d  = idx_q + ADDR_W'(1);
               pf_cnt_d  = LAT_M1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         wdat_q    <= '0;
         dat_q     <= '0;
         hit_q     <= 1'b0;
         hit_cnt_q <= '0;
         pf_v_q    <= 1'b0;
         pf_busy_q <= 1'b0;
         pf_idx_q  <= '0;
         pf_cnt_q  <= '0;
         pf_dat_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         wdat_q    <= wdat_d;
         dat_q     <= dat_d;
         hit_q     <= hit_d;
         hit_cnt_q <= hit_cnt_d;
         pf_v_q    <= pf_v_d;
         pf_busy_q <= pf_busy_d;
         pf_idx_q  <= pf_idx_d;
         pf_cnt_q  <= pf_cnt_d;
         pf_dat_q  <= pf_dat_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (state_q == S_ACK && we_q)
         for (int b = 0; b < 4; b++)
            if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
   end

   assign wbs_ack_o = (state_q == S_ACK);
   assign wbs_dat_o = dat_q;
   assign hit_cnt_o = hit_cnt_q;

endmodule

// File: tb/tb_user_bram_wb_prefetch.sv
// Bench for user_bram_wb_prefetch: directed plan items plus random traffic
// checked against an edge-timed reference model of memory and prefetch.
module tb_user_bram_wb_prefetch;
   localparam int D = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0, wdat = 32'h0;
   logic        ack;
   logic [31:0] rdat;
   logic [15:0] hits;

   user_bram_wb_prefetch #(.DELAYS(D), .ADDR_W(10), .BASE_HI(8'h38)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
      .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
      .wbs_ack_o(ack), .wbs_dat_o(rdat), .hit_cnt_o(hits));

   always #5 clk = ~clk;

   longint edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int n_vec = 0, n_err = 0;

   // reference model: memory image, prefetch target and the edge it becomes valid
   logic [31:0] mem_m [1024];
   bit          pf_exists = 0;
   int          pf_idx = 0;
   longint      pf_ready = 0;
   int          hit_m = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic xfer(input bit w, input int idx, input logic [3:0] s,
                       input logic [31:0] d, input bit drop);
      longint eacc, exp_edge, got_edge;
      bit     is_hit, got;
      logic [31:0] exp_d;
      eacc   = edge_cnt + 1;
      is_hit = 0;
      if (!w && pf_exists && idx == pf_idx) begin
         is_hit   = 1;
         exp_edge = (pf_ready <= eacc - 1) ? eacc : pf_ready;
      end else begin
         exp_edge = eacc + D - 1;
         if (pf_exists && pf_ready > eacc - 1) pf_exists = 0;
         if (w && pf_exists && idx == pf_idx) pf_exists = 0;
      end
      exp_d = w ? 32'h0 : mem_m[idx];
      cyc = 1; stb = 1; we = w; sel = s; wdat = d;
      adr = 32'h3800_0000 | (idx << 2);
      got = 0;
      got_edge = 0;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (drop) begin cyc = 0; stb = 0; end
         if (ack) begin got = 1; got_edge = edge_cnt; break; end
      end
      if (!got) begin
         check("ack_timeout", 32'd0, 32'd1);
         cyc = 0; stb = 0;
         return;
      end
      check(w ? "wr_latency" : "rd_latency", 32'(got_edge - eacc + 1), 32'(exp_edge - eacc + 1));
      check(w ? "wr_dat_o" : "rd_data", rdat, exp_d);
      if (w) begin
         for (int b = 0; b < 4; b++) if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
         pf_exists = 1;
         pf_idx    = (idx + 1) % 1024;
         pf_ready  = exp_edge + D;
      end
      if (is_hit && hit_m < 65535) hit_m++;
      cyc = 0; stb = 0;
      @(negedge clk);
      check("ack_one_cycle", {31'd0, ack}, 32'd0);
      check("hit_cnt", {16'd0, hits}, 32'(hit_m));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic outside(input logic [31:0] a);
      int acks = 0;
      cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = a;
      repeat (3 * D) begin
         @(negedge clk);
         if (ack) acks++;
      end
      cyc = 0; stb = 0;
      check("out_of_window_ack", 32'(acks), 32'd0);
      @(negedge clk);
   endtask

   function automatic int pick(input int last);
      int r;
      if ($urandom_range(0, 1) == 1 && (last < 15 || last >= 1020))
         return (last + 1) % 1024;
      r = $urandom_range(0, 19);
      return (r < 16) ? r : 1004 + r;
   endfunction

   initial begin
      int last;
      foreach (mem_m[i]) mem_m[i] = 32'h0;
      // reset with a write request already on the bus
      cyc = 1; stb = 1; we = 1; sel = 4'hF; wdat = 32'hA5A5_5A5A; adr = 32'h3800_0000;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_dat", rdat, 32'd0);
      check("rst_hits", {16'd0, hits}, 32'd0);
      rst = 0;
      xfer(1, 0, 4'hF, 32'hA5A5_5A5A, 0);

      for (int i = 1; i < 16; i++) xfer(1, i, 4'hF, $urandom, 0);
      for (int i = 1020; i < 1024; i++) xfer(1, i, 4'hF, $urandom, 0);

      xfer(1, 4, 4'hF, 32'hDEAD_BEEF, 0);
      xfer(0, 4, 4'h0, 32'h0, 0);
      check("deadbeef", mem_m[4], 32'hDEAD_BEEF);
      xfer(1, 5, 4'hF, 32'h1122_3344, 0);
      xfer(0, 4, 4'h0, 32'h0, 0);
      idle(12);
      xfer(0, 5, 4'h0, 32'h0, 0);
      xfer(0, 4, 4'h0, 32'h0, 0);
      xfer(0, 5, 4'h0, 32'h0, 0);
      xfer(0, 4, 4'h0, 32'h0, 0);
      xfer(1, 5, 4'h3, 32'h0, 0);
      xfer(0, 5, 4'h0, 32'h0, 0);
      check("partial_write", mem_m[5], 32'h1122_0000);
      outside(32'h3000_0000);
      xfer(0, 1023, 4'h0, 32'h0, 0);
      idle(12);
      xfer(0, 0, 4'h0, 32'h0, 0);
      xfer(1, 7, 4'h0, 32'hFFFF_FFFF, 0);
      xfer(0, 7, 4'h0, 32'h0, 0);
      xfer(1, 8, 4'hF, 32'hCAFE_F00D, 1);
      xfer(0, 8, 4'h0, 32'h0, 1);

      last = 0;
      for (int t = 0; t < 200; t++) begin
         int r, ix;
         r  = $urandom_range(0, 99);
         ix = pick(last);
         if (r < 4) outside({8'h30 + 8'($urandom_range(0, 7)), 24'($urandom)});
         else xfer(r < 30, ix, 4'($urandom), $urandom, $urandom_range(0, 9) == 0);
         last = ix;
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 12));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
